// File: rtl/io_port_peripheral.sv
// I/O-pin side peripheral: buffered input port with arrival interrupt, buffered output port
// drained over valid/ready. Optional sticky error flags via IO_PORT_OVERFLOW_FLAG_EN.
module io_port_peripheral #(
  parameter int DATA_W    = 16,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int INT_PULSE = 2
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic [DATA_W-1:0] extInData,
  input  logic              extInValid,
  output logic              extInReady,
  input  logic              inPortRead,
  output logic [DATA_W-1:0] inputPort,
  output logic              inEmpty,
  output logic              interrupt,
  input  logic [DATA_W-1:0] outputPort,
  input  logic              outPortWrite,
  output logic [DATA_W-1:0] extOutData,
  output logic              extOutValid,
  input  logic              extOutReady,
  output logic              outFull
`ifdef IO_PORT_OVERFLOW_FLAG_EN
  ,
  output logic [1:0]        ioError
`endif
);
  // Handshake: a word moves on an edge where valid && ready are both high; ready depends
  // only on registered state, never combinationally on the partner's valid.
  localparam int IN_PW  = $clog2(IN_DEPTH);
  localparam int IN_CW  = IN_PW + 1;
  localparam int OUT_PW = $clog2(OUT_DEPTH);
  localparam int OUT_CW = OUT_PW + 1;
  localparam int IW     = $clog2(INT_PULSE + 1);

  logic [DATA_W-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_W-1:0] in_mem_d  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];
  logic [DATA_W-1:0] out_mem_d [OUT_DEPTH];

  logic [IN_PW-1:0]  in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_PW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic [IW-1:0]     int_cnt_q, int_cnt_d;

  logic in_full, in_empty, in_push, in_pop, int_trigger;
  logic out_full, out_empty, out_push, out_pop;

`ifdef IO_PORT_OVERFLOW_FLAG_EN
  logic [1:0] err_q, err_d;
`endif

  always_comb begin
    in_full     = (in_cnt_q == IN_CW'(IN_DEPTH));
    in_empty    = (in_cnt_q == '0);
    in_push     = extInValid && !in_full;
    in_pop      = inPortRead && !in_empty;
    int_trigger = in_push && in_empty;

    in_mem_d = in_mem_q;
    if (in_push) in_mem_d[in_wr_q] = extInData;
    in_wr_d = in_push ? in_wr_q + IN_PW'(1) : in_wr_q;
    in_rd_d = in_pop  ? in_rd_q + IN_PW'(1) : in_rd_q;
    case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + IN_CW'(1);
      2'b01:   in_cnt_d = in_cnt_q - IN_CW'(1);
      default: in_cnt_d = in_cnt_q;
    endcase

    // A running pulse is never extended or restarted by a new arrival.
    if (int_cnt_q != '0)  int_cnt_d = int_cnt_q - IW'(1);
    else if (int_trigger) int_cnt_d = IW'(INT_PULSE);
    else                  int_cnt_d = int_cnt_q;
  end

  always_comb begin
    out_full  = (out_cnt_q == OUT_CW'(OUT_DEPTH));
    out_empty = (out_cnt_q == '0);
    out_push  = outPortWrite && !out_full;
    out_pop   = !out_empty && extOutReady;

    out_mem_d = out_mem_q;
    if (out_push) out_mem_d[out_wr_q] = outputPort;
    out_wr_d = out_push ? out_wr_q + OUT_PW'(1) : out_wr_q;
    out_rd_d = out_pop  ? out_rd_q + OUT_PW'(1) : out_rd_q;
    case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

`ifdef IO_PORT_OVERFLOW_FLAG_EN
  always_comb begin
    err_d = err_q | {outPortWrite && out_full, inPortRead && in_empty};
  end
`endif

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      in_rd_q   <= '0;
      in_wr_q   <= '0;
      in_cnt_q  <= '0;
      out_rd_q  <= '0;
      out_wr_q  <= '0;
      out_cnt_q <= '0;
      int_cnt_q <= '0;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
      err_q     <= '0;
`endif
    end else begin
      in_rd_q   <= in_rd_d;
      in_wr_q   <= in_wr_d;
      in_cnt_q  <= in_cnt_d;
      out_rd_q  <= out_rd_d;
      out_wr_q  <= out_wr_d;
      out_cnt_q <= out_cnt_d;
      int_cnt_q <= int_cnt_d;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
      err_q     <= err_d;
`endif
    end
  end

  // Storage needs no reset: every visible read is gated by the count.
  always_ff @(posedge clk1) begin
    in_mem_q  <= in_mem_d;
    out_mem_q <= out_mem_d;
  end

  assign extInReady  = !in_full;
  assign inEmpty     = in_empty;
  assign inputPort   = in_empty ? '0 : in_mem_q[in_rd_q];
  assign interrupt   = (int_cnt_q != '0);
  assign extOutValid = !out_empty;
  assign extOutData  = out_empty ? '0 : out_mem_q[out_rd_q];
  assign outFull     = out_full;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
  assign ioError     = err_q;
`endif

endmodule

// File: tb/tb_io_port_peripheral.sv
// Bench for io_port_peripheral: directed vector table, async-reset and error-flag sequences,
// then randomized traffic against a queue-based reference model.
module tb_io_port_peripheral;
  localparam int DEPTH     = 4;
  localparam int INT_PULSE = 2;

  logic        clk1, reset;
  logic [15:0] ext_in_data, input_port, output_port, ext_out_data;
  logic        ext_in_valid, ext_in_ready, in_port_read, in_empty, irq;
  logic        out_port_write, ext_out_valid, ext_out_ready, out_full;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
  logic [1:0]  io_error;
`endif

  io_port_peripheral dut (
    .clk1(clk1), .reset(reset),
    .extInData(ext_in_data), .extInValid(ext_in_valid), .extInReady(ext_in_ready),
    .inPortRead(in_port_read), .inputPort(input_port), .inEmpty(in_empty),
    .interrupt(irq),
    .outputPort(output_port), .outPortWrite(out_port_write),
    .extOutData(ext_out_data), .extOutValid(ext_out_valid), .extOutReady(ext_out_ready),
    .outFull(out_full)
`ifdef IO_PORT_OVERFLOW_FLAG_EN
    , .ioError(io_error)
`endif
  );

  // Clock / reset
  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle_inputs();
    ext_in_valid = 1'b0; ext_in_data = '0; in_port_read = 1'b0;
    out_port_write = 1'b0; output_port = '0; ext_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Directed vector table
  typedef struct {
    logic        iv;  logic [15:0] id;  logic rd;
    logic        ow;  logic [15:0] od;  logic ordy;
    logic [15:0] e_ip; logic e_emp; logic e_irq; logic e_irdy;
    logic        e_ov; logic [15:0] e_od; logic e_full;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic iv, input logic [15:0] id, input logic rd,
                     input logic ow, input logic [15:0] od, input logic ordy,
                     input logic [15:0] e_ip, input logic e_emp, input logic e_irq,
                     input logic e_irdy, input logic e_ov, input logic [15:0] e_od,
                     input logic e_full);
    vec_t v;
    v = '{iv, id, rd, ow, od, ordy, e_ip, e_emp, e_irq, e_irdy, e_ov, e_od, e_full};
    vecs.push_back(v);
  endtask

  // Reference model
  logic [15:0] in_exp_q[$];
  logic [15:0] out_exp_q[$];
  int          m_int_left;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
  logic [1:0]  m_err;
`endif

  task automatic model_clear();
    in_exp_q.delete();
    out_exp_q.delete();
    m_int_left = 0;
`ifdef IO_PORT_OVERFLOW_FLAG_EN
    m_err = 2'b00;
`endif
  endtask

  // Applies the currently driven inputs to the model as one clock edge.
  task automatic model_edge();
    bit in_push, in_pop, out_push, out_pop, trig;
    in_push  = ext_in_valid && (in_exp_q.size() < DEPTH);
    in_pop   = in_port_read && (in_exp_q.size() > 0);
    trig     = in_push && (in_exp_q.size() == 0);
    out_push = out_port_write && (out_exp_q.size() < DEPTH);
    out_pop  = ext_out_ready && (out_exp_q.size() > 0);
`ifdef IO_PORT_OVERFLOW_FLAG_EN
    if (in_port_read && in_exp_q.size() == 0) m_err[0] = 1'b1;
    if (out_port_write && out_exp_q.size() == DEPTH) m_err[1] = 1'b1;
`endif
    if (in_pop) void'(in_exp_q.pop_front());
    if (in_push) in_exp_q.push_back(ext_in_data);
    if (out_pop) void'(out_exp_q.pop_front());
    if (out_push) out_exp_q.push_back(output_port);
    if (m_int_left > 0) m_int_left--;
    else if (trig) m_int_left = INT_PULSE;
  endtask

  task automatic compare_model(input string tag);
    logic [15:0] e_ip, e_od;
    e_ip = (in_exp_q.size() > 0) ? in_exp_q[0] : 16'h0;
    e_od = (out_exp_q.size() > 0) ? out_exp_q[0] : 16'h0;
    check({tag, " input_port"}, 32'(input_port), 32'(e_ip));
    check({tag, " in_empty"}, 32'(in_empty), 32'(in_exp_q.size() == 0));
    check({tag, " ext_in_ready"}, 32'(ext_in_ready), 32'(in_exp_q.size() < DEPTH));
    check({tag, " interrupt"}, 32'(irq), 32'(m_int_left > 0));
    check({tag, " ext_out_valid"}, 32'(ext_out_valid), 32'(out_exp_q.size() > 0));
    check({tag, " ext_out_data"}, 32'(ext_out_data), 32'(e_od));
    check({tag, " out_full"}, 32'(out_full), 32'(out_exp_q.size() == DEPTH));
`ifdef IO_PORT_OVERFLOW_FLAG_EN
    check({tag, " io_error"}, 32'(io_error), 32'(m_err));
`endif
  endtask

  initial begin
    int pv[4], prd[4], pw[4], prdy[4];
    pv  = '{80, 20, 50, 90};  prd  = '{20, 80, 50, 90};
    pw  = '{85, 15, 50, 90};  prdy = '{15, 85, 50, 90};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("reset input_port", 32'(input_port), 32'h0);
    check("reset in_empty", 32'(in_empty), 32'h1);
    check("reset ext_in_ready", 32'(ext_in_ready), 32'h1);
    check("reset interrupt", 32'(irq), 32'h0);
    check("reset ext_out_valid", 32'(ext_out_valid), 32'h0);
    check("reset ext_out_data", 32'(ext_out_data), 32'h0);
    check("reset out_full", 32'(out_full), 32'h0);

    //   iv id        rd  ow od       rdy  ip        emp irq irdy ov od       full
    add(1, 16'h1234, 0,  0, 16'h0000, 0,  16'h1234, 0,  1,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 0,  16'h1234, 0,  1,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 0,  16'h1234, 0,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 1,  0, 16'h0000, 0,  16'h0000, 1,  0,  1,   0, 16'h0000, 0);
    add(1, 16'hA001, 0,  0, 16'h0000, 0,  16'hA001, 0,  1,  1,   0, 16'h0000, 0);
    add(1, 16'hA002, 0,  0, 16'h0000, 0,  16'hA001, 0,  1,  1,   0, 16'h0000, 0);
    add(1, 16'hA003, 0,  0, 16'h0000, 0,  16'hA001, 0,  0,  1,   0, 16'h0000, 0);
    add(1, 16'hA004, 0,  0, 16'h0000, 0,  16'hA001, 0,  0,  0,   0, 16'h0000, 0);
    add(1, 16'hA005, 0,  0, 16'h0000, 0,  16'hA001, 0,  0,  0,   0, 16'h0000, 0);
    add(1, 16'hA005, 1,  0, 16'h0000, 0,  16'hA002, 0,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 1,  0, 16'h0000, 0,  16'hA003, 0,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 1,  0, 16'h0000, 0,  16'hA004, 0,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 1,  0, 16'h0000, 0,  16'h0000, 1,  0,  1,   0, 16'h0000, 0);
    add(1, 16'h5555, 0,  0, 16'h0000, 0,  16'h5555, 0,  1,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 0,  16'h5555, 0,  1,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 0,  16'h5555, 0,  0,  1,   0, 16'h0000, 0);
    add(1, 16'hBEEF, 1,  0, 16'h0000, 0,  16'hBEEF, 0,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 1,  0, 16'h0000, 0,  16'h0000, 1,  0,  1,   0, 16'h0000, 0);
    add(0, 16'h0000, 0,  1, 16'h0011, 0,  16'h0000, 1,  0,  1,   1, 16'h0011, 0);
    add(0, 16'h0000, 0,  1, 16'h0022, 0,  16'h0000, 1,  0,  1,   1, 16'h0011, 0);
    add(0, 16'h0000, 0,  1, 16'h0033, 0,  16'h0000, 1,  0,  1,   1, 16'h0011, 0);
    add(0, 16'h0000, 0,  1, 16'h0044, 0,  16'h0000, 1,  0,  1,   1, 16'h0011, 1);
    add(0, 16'h0000, 0,  1, 16'h0055, 0,  16'h0000, 1,  0,  1,   1, 16'h0011, 1);
    add(0, 16'h0000, 0,  0, 16'h0000, 1,  16'h0000, 1,  0,  1,   1, 16'h0022, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 1,  16'h0000, 1,  0,  1,   1, 16'h0033, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 1,  16'h0000, 1,  0,  1,   1, 16'h0044, 0);
    add(0, 16'h0000, 0,  0, 16'h0000, 1,  16'h0000, 1,  0,  1,   0, 16'h0000, 0);

    foreach (vecs[i]) begin
      ext_in_valid   = vecs[i].iv;  ext_in_data = vecs[i].id;  in_port_read  = vecs[i].rd;
      out_port_write = vecs[i].ow;  output_port = vecs[i].od;  ext_out_ready = vecs[i].ordy;
      step();
      check($sformatf("v%0d input_port", i), 32'(input_port), 32'(vecs[i].e_ip));
      check($sformatf("v%0d in_empty", i), 32'(in_empty), 32'(vecs[i].e_emp));
      check($sformatf("v%0d interrupt", i), 32'(irq), 32'(vecs[i].e_irq));
      check($sformatf("v%0d ext_in_ready", i), 32'(ext_in_ready), 32'(vecs[i].e_irdy));
      check($sformatf("v%0d ext_out_valid", i), 32'(ext_out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d ext_out_data", i), 32'(ext_out_data), 32'(vecs[i].e_od));
      check($sformatf("v%0d out_full", i), 32'(out_full), 32'(vecs[i].e_full));
    end

    // Async reset in the middle of an interrupt pulse with two words queued each side
    do_reset();
    ext_in_valid = 1'b1; ext_in_data = 16'h0101; out_port_write = 1'b1; output_port = 16'h0202;
    step();
    ext_in_data = 16'h0102; output_port = 16'h0203;
    step();
    idle_inputs();
    check("pre-async interrupt", 32'(irq), 32'h1);
    check("pre-async input_port", 32'(input_port), 32'h0101);
    check("pre-async ext_out_data", 32'(ext_out_data), 32'h0202);
    reset = 1'b1;
    #2;
    check("async interrupt", 32'(irq), 32'h0);
    check("async ext_out_valid", 32'(ext_out_valid), 32'h0);
    check("async ext_out_data", 32'(ext_out_data), 32'h0);
    check("async input_port", 32'(input_port), 32'h0);
    check("async in_empty", 32'(in_empty), 32'h1);
    check("async ext_in_ready", 32'(ext_in_ready), 32'h1);
    check("async out_full", 32'(out_full), 32'h0);
    #1;
    reset = 1'b0;
    step();
    check("post-async in_empty", 32'(in_empty), 32'h1);
    check("post-async ext_out_valid", 32'(ext_out_valid), 32'h0);
    check("post-async interrupt", 32'(irq), 32'h0);

`ifdef IO_PORT_OVERFLOW_FLAG_EN
    do_reset();
    check("err reset", 32'(io_error), 32'h0);
    in_port_read = 1'b1;
    step();
    in_port_read = 1'b0;
    check("err underflow", 32'(io_error), 32'h1);
    for (int k = 0; k < DEPTH; k++) begin
      out_port_write = 1'b1; output_port = 16'(k);
      step();
    end
    check("err full no overflow yet", 32'(io_error), 32'h1);
    step();
    idle_inputs();
    check("err overflow", 32'(io_error), 32'h3);
    for (int k = 0; k < 3; k++) step();
    check("err sticky", 32'(io_error), 32'h3);
`endif

    // Randomized traffic against the reference model
    do_reset();
    model_clear();
    compare_model("rand reset");
    for (int c = 0; c < 480; c++) begin
      int ph;
      ph = c / 120;
      ext_in_valid   = ($urandom_range(0, 99) < pv[ph]);
      ext_in_data    = 16'($urandom_range(0, 65535));
      in_port_read   = ($urandom_range(0, 99) < prd[ph]);
      out_port_write = ($urandom_range(0, 99) < pw[ph]);
      output_port    = 16'($urandom_range(0, 65535));
      ext_out_ready  = ($urandom_range(0, 99) < prdy[ph]);
      model_edge();
      step();
      compare_model($sformatf("rand c%0d", c));
    end
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/io_port_peripheral.md
Name: io_port_peripheral

Overview:
- Sits on the far side of the processor's I/O pins: it feeds `inputPort` and `interrupt`, and consumes `outputPort`.
- Input side: external producer words are buffered in a FIFO. The head word is presented on `inputPort`. An interrupt pulse is raised when fresh data arrives.
- Output side: processor OUT writes are captured into a FIFO and drained by an external consumer with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of port words (matches processor `inputPort`/`outputPort`).
- IN_DEPTH, 4, input FIFO depth; power of two, at least 2.
- OUT_DEPTH, 4, output FIFO depth; power of two, at least 2.
- INT_PULSE, 2, number of cycles `interrupt` stays high per trigger; at least 1.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- extInData  in  DATA_W  word from external producer.
- extInValid  in  1  producer has a word.
- extInReady  out  1  peripheral accepts a word (input FIFO not full).
- inPortRead  in  1  processor IN strobe; pops input FIFO head.
- inputPort  out  DATA_W  input FIFO head word; 0 when empty.
- inEmpty  out  1  input FIFO empty.
- interrupt  out  1  interrupt request to processor.
- outputPort  in  DATA_W  processor output word.
- outPortWrite  in  1  processor OUT strobe; pushes `outputPort`.
- extOutData  out  DATA_W  output FIFO head word.
- extOutValid  out  1  output FIFO not empty.
- extOutReady  in  1  consumer takes word.
- outFull  out  1  output FIFO full.

Behaviour:
- Reset (async, any time, including mid-pulse or mid-transfer):
  - Both FIFOs cleared: pointers and counts = 0.
  - `interrupt` = 0 and pulse counter = 0.
  - Outputs: `inputPort` = 0, `inEmpty` = 1, `extInReady` = 1, `extOutValid` = 0, `extOutData` = 0, `outFull` = 0.
  - Storage contents are don't-care.
- Input FIFO:
  - Push when `extInValid && extInReady`.
  - `extInReady` = !full. It depends on count only, not on `inPortRead`; a full FIFO does not accept a word in a pop cycle.
  - Pop when `inPortRead && !inEmpty`. `inPortRead` while empty is ignored and changes no state.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo depth.
  - `inputPort` is combinational from head storage, gated to 0 when empty. A pushed word is visible the cycle after the push edge.
- Interrupt:
  - Trigger = count was 0 before the edge and a push occurs at that edge.
  - On trigger, `interrupt` goes high from the next cycle for exactly INT_PULSE cycles (registered down-counter).
  - A trigger while a pulse is in progress is ignored; the pulse is not extended or restarted.
  - No trigger when count goes 1 -> 1 (simultaneous push and pop), and none on pushes into a non-empty FIFO.
- Output FIFO:
  - Push when `outPortWrite && !outFull`. `outPortWrite` while full drops the word and leaves state unchanged.
  - Pop when `extOutValid && extOutReady`.
  - Simultaneous push and pop allowed at any count; when full, the pop frees no space until the next cycle.
  - `extOutData` = head word, registered-storage read, stable while `extOutValid && !extOutReady`.
- Counts are $clog2(depth)+1 bits wide; full is count == depth.

Optional Feature:
- Macro: IO_PORT_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output `ioError` (2 bits, sticky, reset 0).
  - bit0 sets on `inPortRead` while input FIFO empty.
  - bit1 sets on `outPortWrite` while output FIFO full.
  - Cleared only by reset.
- Undefined:
  - Port absent.
  - Underflow and overflow events are silently ignored as described above.

Test Plan:
- Reset, then push 0x1234 with `extInValid` for 1 cycle -> next cycle `inputPort` = 0x1234, `inEmpty` = 0, `interrupt` high for exactly 2 cycles.
- Push 0xA001..0xA004 back to back -> `extInReady` = 0 after the 4th. A 5th word 0xA005 is held off. Pop 4 times -> `inputPort` shows A001, A002, A003, A004 in order, then 0 with `inEmpty` = 1.
- With count = 1, assert push 0xBEEF and `inPortRead` in the same cycle -> count stays 1, `inputPort` = 0xBEEF, `interrupt` stays 0.
- Output side with `extOutReady` = 0:
  - `outPortWrite` of 0x0011..0x0055 (5 writes) -> `outFull` = 1 after 4; 0x0055 is dropped.
  - Then raise `extOutReady` -> consumer receives 0x0011, 0x0022, 0x0033, 0x0044, then `extOutValid` = 0.
- Assert reset asynchronously mid-interrupt-pulse with 2 words queued on each side -> `interrupt`, `extOutValid` and `inputPort` go low/0 immediately, without waiting for a clock edge.
- With IO_PORT_OVERFLOW_FLAG_EN defined:
  - `inPortRead` while empty -> `ioError` = 2'b01.
  - Write to a full output FIFO -> `ioError` = 2'b11, and it stays set after traffic stops.
